// File: rtl/traffic_phase_timer_pkg.sv
// traffic_phase_timer_pkg: phase codes and duration lookup shared with the light FSM
package traffic_pkg;
  typedef enum logic [1:0] {
    RED        = 2'b00,
    RED_YELLOW = 2'b01,
    GREEN      = 2'b10,
    YELLOW     = 2'b11
  } phase_e;
  localparam logic [1:0] PH_RED        = 2'b00;
  localparam logic [1:0] PH_RED_YELLOW = 2'b01;
  localparam logic [1:0] PH_GREEN      = 2'b10;
  localparam logic [1:0] PH_YELLOW     = 2'b11;
  function automatic int phase_dur(phase_e p, int red_t, int ry_t, int green_t, int yellow_t);
    return p == RED ? red_t : p == RED_YELLOW ? ry_t : p == GREEN ? green_t : yellow_t;
  endfunction
endpackage

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: phase sequencer with pedestrian green shortening and flashing-yellow mode
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter int RED_TICKS       = 10,
  parameter int RY_TICKS        = 2,
  parameter int GREEN_TICKS     = 10,
  parameter int GREEN_MIN_TICKS = 4,
  parameter int YELLOW_TICKS    = 3
) (
  input  logic             timer_clk,
  input  logic             rstb,
  input  logic             enable_i,
  input  logic             ped_req_i,
  input  logic             flash_req_i,
  output logic [1:0]       phase_o,
  output logic             advance_o,
  output logic [CNT_W-1:0] remaining_o,
  output logic             ped_pending_o,
  output logic             flash_o,
  output logic             blink_o
);
  if (RED_TICKS < 1 || RY_TICKS < 1 || GREEN_TICKS < 1 || GREEN_MIN_TICKS < 1 || YELLOW_TICKS < 1 ||
      GREEN_MIN_TICKS > GREEN_TICKS ||
      RED_TICKS >= 2**CNT_W || RY_TICKS >= 2**CNT_W || GREEN_TICKS >= 2**CNT_W ||
      GREEN_MIN_TICKS >= 2**CNT_W || YELLOW_TICKS >= 2**CNT_W) begin : g_bad_params
    $fatal(1, "traffic_phase_timer: invalid tick parameters");
  end
  localparam logic [CNT_W-1:0] SHORT_AT = CNT_W'(GREEN_TICKS - GREEN_MIN_TICKS);
  phase_e phase, phase_n, step;
  logic [CNT_W-1:0] rem_n;
  logic adv_n, ped_n, flash_n, blink_n, go;
  function automatic logic [CNT_W-1:0] load(phase_e p);
    return CNT_W'(phase_dur(p, RED_TICKS, RY_TICKS, GREEN_TICKS, YELLOW_TICKS) - 1);
  endfunction
  assign phase_o = phase;
  // next-state: flash entry/hold beats flash exit beats normal counting
  always_comb begin
    phase_n = phase;
    rem_n   = remaining_o;
    adv_n   = 1'b0;
    ped_n   = ped_pending_o;
    flash_n = flash_o;
    blink_n = 1'b0;
    step    = phase_e'(phase + 2'b01);
    go      = remaining_o == '0 || (phase == GREEN && ped_pending_o && remaining_o <= SHORT_AT);
    if (flash_req_i) begin
      phase_n = YELLOW;
      rem_n   = '0;
      adv_n   = !flash_o;
      ped_n   = 1'b0;
      flash_n = 1'b1;
      blink_n = !(flash_o && blink_o);
    end else if (flash_o) begin
      phase_n = RED;
      rem_n   = load(RED);
      adv_n   = 1'b1;
      ped_n   = 1'b0;
      flash_n = 1'b0;
    end else if (enable_i) begin
      ped_n   = ped_pending_o || (ped_req_i && phase != RED);
      phase_n = go ? step : phase;
      rem_n   = go ? load(step) : remaining_o - 1'b1;
      adv_n   = go;
      if (go && step == RED) ped_n = 1'b0;
    end
  end
  // state register with asynchronous reset back to the start of RED
  always_ff @(posedge timer_clk or negedge rstb) begin
    if (!rstb) begin
      phase         <= RED;
      remaining_o   <= load(RED);
      advance_o     <= 1'b0;
      ped_pending_o <= 1'b0;
      flash_o       <= 1'b0;
      blink_o       <= 1'b0;
    end else begin
      phase         <= phase_n;
      remaining_o   <= rem_n;
      advance_o     <= adv_n;
      ped_pending_o <= ped_n;
      flash_o       <= flash_n;
      blink_o       <= blink_n;
    end
  end
endmodule
